// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, micro-op class and immediate format
// encodings, the decoded bundle, and immediate assembly.
package decode_pkg;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    UOP_ALU_R   = 4'd0,
    UOP_ALU_I   = 4'd1,
    UOP_LOAD    = 4'd2,
    UOP_STORE   = 4'd3,
    UOP_BRANCH  = 4'd4,
    UOP_JAL     = 4'd5,
    UOP_JALR    = 4'd6,
    UOP_LUI     = 4'd7,
    UOP_AUIPC   = 4'd8,
    UOP_ILLEGAL = 4'd9
  } uop_class_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    uop_class_e  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } uop_t;

  function automatic logic [31:0] build_imm(imm_fmt_e fmt, logic [31:0] instr);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv32i_field_decode.sv
// Purely combinational RV32I field decoder: instruction word to class, masked
// register indices, funct fields and sign-extended immediate.
module rv32i_field_decode
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [3:0]  cls_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [31:0] imm_o,
  output logic        illegal_o
);

  uop_class_e cls;
  imm_fmt_e   fmt;
  logic       use_rd;
  logic       use_rs1;
  logic       use_rs2;

  always_comb begin
    cls     = UOP_ILLEGAL;
    fmt     = IMM_NONE;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (instr_i[6:0])
      OP_ALU_R:  begin cls = UOP_ALU_R;  use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_ALU_I:  begin cls = UOP_ALU_I;  fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_LOAD:   begin cls = UOP_LOAD;   fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_STORE:  begin cls = UOP_STORE;  fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BRANCH: begin cls = UOP_BRANCH; fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_JAL:    begin cls = UOP_JAL;    fmt = IMM_J; use_rd = 1'b1; end
      OP_JALR:   begin cls = UOP_JALR;   fmt = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_LUI:    begin cls = UOP_LUI;    fmt = IMM_U; use_rd = 1'b1; end
      OP_AUIPC:  begin cls = UOP_AUIPC;  fmt = IMM_U; use_rd = 1'b1; end
      default:   ;
    endcase
  end

  // Fields a format does not carry are zeroed so rename never sees phantom dependencies.
  assign cls_o     = cls;
  assign rd_o      = use_rd  ? instr_i[11:7]  : 5'd0;
  assign rs1_o     = use_rs1 ? instr_i[19:15] : 5'd0;
  assign rs2_o     = use_rs2 ? instr_i[24:20] : 5'd0;
  assign funct3_o  = instr_i[14:12];
  assign funct7_o  = (cls == UOP_ALU_R) ? instr_i[31:25] : 7'd0;
  assign imm_o     = build_imm(fmt, instr_i);
  assign illegal_o = (cls == UOP_ILLEGAL) || (instr_i == 32'd0);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: accepts {pc, instr} from fetch, decodes it and holds the result in a
// 2-entry elastic buffer (output + skid register) feeding rename/dispatch.
module decode_stage
  import decode_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   fb_valid,
  input  logic [ADDR_WIDTH-1:0]  fb_pc,
  input  logic [INSTR_WIDTH-1:0] fb_instr,
  output logic                   fb_ready,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [ADDR_WIDTH-1:0]  dec_pc,
  output logic [4:0]             dec_rd,
  output logic [4:0]             dec_rs1,
  output logic [4:0]             dec_rs2,
  output logic [2:0]             dec_funct3,
  output logic [6:0]             dec_funct7,
  output logic [31:0]            dec_imm,
  output logic [3:0]             dec_class,
  output logic                   dec_illegal
);

  logic [3:0]  in_cls;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        in_illegal;
  uop_t        in_uop;

  rv32i_field_decode u_field_decode (
    .instr_i   (fb_instr),
    .cls_o     (in_cls),
    .rd_o      (in_rd),
    .rs1_o     (in_rs1),
    .rs2_o     (in_rs2),
    .funct3_o  (in_funct3),
    .funct7_o  (in_funct7),
    .imm_o     (in_imm),
    .illegal_o (in_illegal)
  );

  always_comb begin
    in_uop.cls     = uop_class_e'(in_cls);
    in_uop.rd      = in_rd;
    in_uop.rs1     = in_rs1;
    in_uop.rs2     = in_rs2;
    in_uop.funct3  = in_funct3;
    in_uop.funct7  = in_funct7;
    in_uop.imm     = in_imm;
    in_uop.illegal = in_illegal;
  end

  logic                  out_valid_q,  out_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  uop_t                  out_uop_q,    out_uop_d;
  uop_t                  skid_uop_q,   skid_uop_d;
  logic [ADDR_WIDTH-1:0] out_pc_q,     out_pc_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q,    skid_pc_d;

  logic accept;
  logic consume;

  // fb_ready comes straight from a flop, so fetch never sees a path from dec_ready.
  assign fb_ready = ~skid_valid_q;
  assign accept   = fb_valid & fb_ready;
  assign consume  = out_valid_q & dec_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_uop_d    = out_uop_q;
    out_pc_d     = out_pc_q;
    skid_uop_d   = skid_uop_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (consume) begin
        out_uop_d    = skid_uop_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || consume) begin
      out_valid_d = accept;
      if (accept) begin
        out_uop_d = in_uop;
        out_pc_d  = fb_pc;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_uop_d   = in_uop;
      skid_pc_d    = fb_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_uop_q    <= '0;
      skid_uop_q   <= '0;
      out_pc_q     <= '0;
      skid_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_uop_q    <= out_uop_d;
      skid_uop_q   <= skid_uop_d;
      out_pc_q     <= out_pc_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign dec_valid   = out_valid_q;
  assign dec_pc      = out_pc_q;
  assign dec_rd      = out_uop_q.rd;
  assign dec_rs1     = out_uop_q.rs1;
  assign dec_rs2     = out_uop_q.rs2;
  assign dec_funct3  = out_uop_q.funct3;
  assign dec_funct7  = out_uop_q.funct7;
  assign dec_imm     = out_uop_q.imm;
  assign dec_class   = out_uop_q.cls;
  assign dec_illegal = out_uop_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Consumer end of the fetch interface: accepts {pc, instr} from the fetch buffer under a valid/ready handshake.
- Decodes RV32I fields, class flags and a sign-extended immediate, and presents one registered decoded micro-op to rename/dispatch.
- Holds a 2-entry elastic buffer (output register + skid register), so fetch sees a registered ready and no instruction is lost or duplicated under back-pressure.

Parameters:
- ADDR_WIDTH, 12, width of the PC carried with each instruction.
- INSTR_WIDTH, 32, instruction width (fixed RV32I; other values unsupported).

Ports:
- clk  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high.
- flush  input  1  discard all buffered instructions (branch redirect).
- fb_valid  input  1  fetch side holds a valid instruction.
- fb_pc  input  ADDR_WIDTH  PC of the offered instruction.
- fb_instr  input  INSTR_WIDTH  offered instruction word.
- fb_ready  output  1  decode can accept this cycle; equals !skid_valid (registered, no combinational path from dec_ready).
- dec_valid  output  1  decoded micro-op valid.
- dec_ready  input  1  downstream accepts the micro-op this cycle.
- dec_pc  output  ADDR_WIDTH  PC of the micro-op.
- dec_rd, dec_rs1, dec_rs2  output  5 each  register indices; forced 0 when the format has no such field.
- dec_funct3  output  3  instr[14:12].
- dec_funct7  output  7  instr[31:25] for R-type, else 0.
- dec_imm  output  32  sign-extended immediate per format; 0 for R-type/illegal.
- dec_class  output  4  uop class encoding from decode_pkg.
- dec_illegal  output  1  opcode not in RV32I base set, or instr == 0.

Behaviour:
- Reset (clk edge with reset=1): out_valid=0, skid_valid=0, all dec_* outputs 0, fb_ready=1 on the following cycle. Reset overrides flush and all handshakes.
- Transfers: input accepted iff fb_valid & fb_ready; output consumed iff dec_valid & dec_ready.
- Decode is combinational on fb_instr; the decoded bundle (not the raw word) is what gets registered. Latency from acceptance to dec_valid is 1 cycle.
- Register update rules (out = output register, skid = skid register):
  - out empty or consumed, skid empty, input accepted: load out from input.
  - out full and not consumed, input accepted: load skid from input; fb_ready=0 next cycle.
  - out consumed, skid full: load out from skid, clear skid; input is not accepted (fb_ready=0) this cycle.
  - out consumed, no replacement: out_valid=0.
- Order is strictly preserved. Maximum occupancy is 2. dec_* fields hold stable while dec_valid=1 and dec_ready=0.
- Flush: at that edge out_valid=0 and skid_valid=0, and any same-cycle input is dropped. fb_ready=1 next cycle. Data fields may keep stale values; only the valid bits matter.
- Classes (opcode instr[6:0]):
  - 0110011 ALU_R
  - 0010011 ALU_I
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH
  - 1101111 JAL
  - 1100111 JALR
  - 0110111 LUI
  - 0010111 AUIPC
  - anything else ILLEGAL (dec_illegal=1, class ILLEGAL).
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Field masking:
  - rd is 0 for STORE/BRANCH.
  - rs1 is 0 for LUI/AUIPC/JAL.
  - rs2 is nonzero only for ALU_R/STORE/BRANCH.
- fb_pc is passed through unmodified; there is no PC arithmetic in this block.

Decomposition:
- decode_pkg: opcode localparams, uop class encoding (ALU_R..ILLEGAL, 4 bits), immediate format encoding.
- Sub-module rv32i_field_decode: purely combinational instr → {class, rd, rs1, rs2, funct3, funct7, imm, illegal}.
- decode_stage owns the handshake, the two registers and flush/reset.

Test Plan:
- Reset held 2 cycles, then released → dec_valid=0, fb_ready=1, all fields 0.
- fb_instr=0x00500093 (addi x1,x0,5), pc=0x000, dec_ready=1 → next cycle dec_valid=1, class ALU_I, rd=1, rs1=0, imm=0x00000005.
- 0x0020A423 (sw x2,8(x1)) → class STORE, rd=0, rs1=1, rs2=2, funct3=2, imm=0x00000008. Then 0xFE000EE3 (beq x0,x0,-4) → class BRANCH, imm=0xFFFFFFFC.
- Stream pcs 0x0,0x4,0x8,0xC with dec_ready=0 for 3 cycles → fb_ready drops after 2 accepts. Outputs stay at pc 0x0. On release, pcs appear 0x0,0x4,0x8,0xC in order, none lost or duplicated.
- Two entries buffered, flush=1 with fb_valid=1 offering 0x123452B7 → next cycle dec_valid=0, fb_ready=1. Re-offer 0x123452B7 → class LUI, rd=5, imm=0x12345000.
- fb_instr=0x00000000 and 0xFFFFFFFF → dec_illegal=1, class ILLEGAL, imm=0. reset asserted while skid full → both entries cleared next cycle.
